// File: rtl/msg_stream_player.sv
// msg_stream_player: DEPTH x WIDTH message buffer played out as a
// valid/ready stream with a last marker, optional looping, abort and
// pass/beat counters.
//
// Optional build macro:
//   MSG_STREAM_PLAYER_ASSERT_EN - compiles in concurrent protocol assertions.
//
// Buffer writes may happen in any state. An entry is copied into out_data
// when it is loaded, so rewriting the presented entry only takes effect the
// next time that index is loaded. A load and a write to the same address in
// one cycle return the old data.

module msg_stream_player #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  // buffer write port
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  // playback control
  input  logic             start,
  input  logic [LW-1:0]    len,
  input  logic             loop,
  input  logic             stop,
  // output stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  // status
  output logic             busy,
  output logic [31:0]      passes,
  output logic [31:0]      beats
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam logic [LW-1:0] LEN_MAX  = LW'(DEPTH);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [AW-1:0] IDX_ZERO = '0;
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(DEPTH);

  // Message storage
  logic [WIDTH-1:0] mem [DEPTH];

  // Registered state and its next-state values
  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q,   idx_d;
  logic [LW-1:0]    len_q,   len_d;
  logic             loop_q,  loop_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             last_q,  last_d;
  logic [31:0]      passes_q, passes_d;
  logic [31:0]      beats_q,  beats_d;

  // Derived control terms
  logic             hs;
  logic             at_last;
  logic             wr_ok;
  logic [AW-1:0]    idx_inc;
  logic [LW-1:0]    len_clip;

  assign hs       = (state_q == PLAY) && out_ready;
  assign at_last  = (LW'(idx_q) == (len_q - LEN_ONE));
  assign idx_inc  = idx_q + IDX_ONE;
  assign len_clip = (len > LEN_MAX) ? LEN_MAX : len;
  assign wr_ok    = wr_en && ({1'b0, wr_addr} < ADDR_LIM);

  // Buffer write port; writes are suppressed while rst is high.
  // NOTE: the message array has no reset on purpose; contents survive rst and
  // a reset term here would prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next-state, next-entry and counter computation.
  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    loop_d   = loop_q;
    data_d   = data_q;
    last_d   = last_q;
    passes_d = passes_q;
    beats_d  = beats_q;

    // Counters advance on every handshake, even one that coincides with stop.
    if (hs) begin
      beats_d = beats_q + 32'd1;
      if (at_last) begin
        passes_d = passes_q + 32'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start && !stop && (len != '0)) begin
          state_d = PLAY;
          len_d   = len_clip;
          loop_d  = loop;
          idx_d   = IDX_ZERO;
          data_d  = mem[IDX_ZERO];
          last_d  = (len_clip == LEN_ONE);
        end
      end
      PLAY: begin
        if (stop) begin
          // Abort wins over any next-entry load; out_data keeps its value.
          state_d = IDLE;
          idx_d   = IDX_ZERO;
          last_d  = 1'b0;
        end else if (hs) begin
          if (!at_last) begin
            idx_d  = idx_inc;
            data_d = mem[idx_inc];
            last_d = ((LW'(idx_q) + LEN_ONE) == (len_q - LEN_ONE));
          end else if (loop_q) begin
            idx_d  = IDX_ZERO;
            data_d = mem[IDX_ZERO];
            last_d = (len_q == LEN_ONE);
          end else begin
            state_d = IDLE;
            idx_d   = IDX_ZERO;
            last_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      passes_q <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      data_q   <= data_d;
      last_q   <= last_d;
      passes_q <= passes_d;
      beats_q  <= beats_d;
    end
  end

  assign out_valid = (state_q == PLAY);
  assign busy      = (state_q == PLAY);
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign passes    = passes_q;
  assign beats     = beats_q;

`ifdef MSG_STREAM_PLAYER_ASSERT_EN
  // A stalled beat must stay put and stay valid unless aborted.
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !stop) |=>
      ($stable(out_data) && $stable(out_last) && out_valid));

  // The last marker only accompanies a valid beat.
  a_last_valid: assert property (@(posedge clk) disable iff (rst)
    out_last |-> out_valid);

  // busy and out_valid are the same condition.
  a_busy_valid: assert property (@(posedge clk) disable iff (rst)
    busy == out_valid);

  // The presented index never reaches the latched pass length.
  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    busy |-> (LW'(idx_q) < len_q));
`endif

endmodule
